// File: rtl/frame_capture_buffer.sv
// rtl/frame_capture_buffer.sv - single-shot frame capture into RAM with valid/ready replay
// Optional FRAME_CAPTURE_DECIMATE_EN adds a decim input that thins stored samples within a frame.
module frame_capture_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAME_LEN  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_frame_start,
`ifdef FRAME_CAPTURE_DECIMATE_EN
    input  logic [3:0]            decim,
`endif
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  frame_err
);

    localparam int AW = (FRAME_LEN <= 1) ? 1 : $clog2(FRAME_LEN);
    localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_READOUT = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  rd_all_q, rd_all_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;
    logic                  we;
    logic [AW-1:0]         waddr;
    logic                  keep;
`ifdef FRAME_CAPTURE_DECIMATE_EN
    logic [3:0]            dec_q, dec_d;
`endif

    // Power-of-two depth keeps the index width equal to AW; unused tail entries are trimmed.
    logic [DATA_WIDTH-1:0] mem [0:(1<<AW)-1];
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  rd_en;
    logic                  inflight_q, inflight_last_q;

    logic [1:0]            cnt_q, cnt_d, cnt_p;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
    logic                  last0_q, last0_d, last1_q, last1_d;
    logic                  pop;
    logic [1:0]            occ;

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = buf0_q;
    assign out_last  = out_valid & last0_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign frame_err = err_q;

    assign pop = out_valid & out_ready;
    assign occ = cnt_q + {1'b0, inflight_q};
    // A read is issued only when its word is guaranteed a slot in the two-entry skid.
    assign rd_en = (state_q == S_READOUT) && !rd_all_q && ((occ < 2'd2) || pop);

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = '0;
        rd_all_d = 1'b0;
        err_d    = err_q;
        done_d   = 1'b0;
        we       = 1'b0;
        waddr    = wr_ptr_q;
        keep     = 1'b1;
`ifdef FRAME_CAPTURE_DECIMATE_EN
        dec_d    = dec_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d = S_ARMED;
                    err_d   = 1'b0;
                end
            end
            S_ARMED: begin
                if (in_valid && in_frame_start) begin
                    we       = 1'b1;
                    waddr    = '0;
                    wr_ptr_d = AW'(1);
`ifdef FRAME_CAPTURE_DECIMATE_EN
                    dec_d    = '0;
`endif
                    state_d  = (FRAME_LEN == 1) ? S_READOUT : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (in_valid) begin
                    if (in_frame_start) begin
                        // New boundary mid-frame: flag it and restart the frame on this sample.
                        err_d    = 1'b1;
                        we       = 1'b1;
                        waddr    = '0;
                        wr_ptr_d = AW'(1);
`ifdef FRAME_CAPTURE_DECIMATE_EN
                        dec_d    = '0;
`endif
                    end else begin
`ifdef FRAME_CAPTURE_DECIMATE_EN
                        keep  = (dec_q == decim);
                        dec_d = keep ? 4'd0 : dec_q + 4'd1;
`endif
                        if (keep) begin
                            we = 1'b1;
                            if (wr_ptr_q == LAST_IDX) begin
                                state_d = S_READOUT;
                            end else begin
                                wr_ptr_d = wr_ptr_q + AW'(1);
                            end
                        end
                    end
                end
            end
            S_READOUT: begin
                rd_ptr_d = rd_ptr_q;
                rd_all_d = rd_all_q;
                if (rd_en) begin
                    if (rd_ptr_q == LAST_IDX) begin
                        rd_all_d = 1'b1;
                    end else begin
                        rd_ptr_d = rd_ptr_q + AW'(1);
                    end
                end
                if (pop && last0_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_p   = cnt_q - {1'b0, pop};
        buf0_d  = pop ? buf1_q : buf0_q;
        last0_d = pop ? last1_q : last0_q;
        buf1_d  = buf1_q;
        last1_d = last1_q;
        if (inflight_q) begin
            if (cnt_p == 2'd0) begin
                buf0_d  = ram_q;
                last0_d = inflight_last_q;
            end else begin
                buf1_d  = ram_q;
                last1_d = inflight_last_q;
            end
        end
        cnt_d = cnt_p + {1'b0, inflight_q};
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= in_data;
        end
        if (rd_en) begin
            ram_q <= mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            rd_all_q        <= 1'b0;
            err_q           <= 1'b0;
            done_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            cnt_q           <= 2'd0;
            buf0_q          <= '0;
            buf1_q          <= '0;
            last0_q         <= 1'b0;
            last1_q         <= 1'b0;
`ifdef FRAME_CAPTURE_DECIMATE_EN
            dec_q           <= '0;
`endif
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            rd_all_q        <= rd_all_d;
            err_q           <= err_d;
            done_q          <= done_d;
            inflight_q      <= rd_en;
            inflight_last_q <= (rd_ptr_q == LAST_IDX);
            cnt_q           <= cnt_d;
            buf0_q          <= buf0_d;
            buf1_q          <= buf1_d;
            last0_q         <= last0_d;
            last1_q         <= last1_d;
`ifdef FRAME_CAPTURE_DECIMATE_EN
            dec_q           <= dec_d;
`endif
        end
    end

endmodule
